// File: rtl/adc_spi_responder.sv
// Device-side emulation of an 8-channel 12-bit serial ADC (CS_N/SCLK/SADDR in, SDAT out), oversampled in clk.
// Optional per-channel test ramp data source is enabled with the ADC_RESP_RAMP_EN macro.
module adc_spi_responder #(
   parameter int NUM_CH      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   adc_cs_n,
   input  logic                   adc_sclk,
   input  logic                   adc_saddr,
   output logic                   adc_sdat,
   output logic                   adc_sdat_oe,
   input  logic [12*NUM_CH-1:0]   ch_data,
   input  logic                   ramp_en,
   output logic                   frame_done,
   output logic [2:0]             frame_ch,
   output logic                   proto_err,
   input  logic                   err_clr
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_ABORT  = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_saddr_sync;
   logic                   r_cs_d;
   logic                   r_sclk_d;

   state_t      r_state;
   logic [3:0]  r_edge_cnt;
   logic [1:0]  r_addr_tmp;
   logic [2:0]  r_next_ch;
   logic [2:0]  r_cur_ch;
   logic [10:0] r_shift;
   logic        r_sdat;
   logic        r_sdat_oe;
   logic        r_frame_done;
   logic [2:0]  r_frame_ch;
   logic        r_proto_err;

   logic        w_cs_s;
   logic        w_sclk_s;
   logic        w_saddr_s;
   logic        w_cs_fall;
   logic        w_cs_rise;
   logic        w_sclk_rise;
   logic        w_sclk_fall;
   logic        w_abort;
   logic        w_wrap;
   logic [11:0] w_ch_sel;
   logic [11:0] w_load_data;

   // CS_N is cleared to 0 in reset so a CS_N still held low never looks like a fresh fall.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cs_sync    <= {SYNC_STAGES{1'b0}};
         r_sclk_sync  <= {SYNC_STAGES{1'b1}};
         r_saddr_sync <= {SYNC_STAGES{1'b0}};
         r_cs_d       <= 1'b0;
         r_sclk_d     <= 1'b1;
      end else begin
         r_cs_sync    <= {r_cs_sync[SYNC_STAGES-2:0], adc_cs_n};
         r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], adc_sclk};
         r_saddr_sync <= {r_saddr_sync[SYNC_STAGES-2:0], adc_saddr};
         r_cs_d       <= r_cs_sync[SYNC_STAGES-1];
         r_sclk_d     <= r_sclk_sync[SYNC_STAGES-1];
      end
   end

   assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_saddr_s   = r_saddr_sync[SYNC_STAGES-1];
   assign w_cs_fall   = r_cs_d & ~w_cs_s;
   assign w_cs_rise   = ~r_cs_d & w_cs_s;
   assign w_sclk_rise = ~r_sclk_d & w_sclk_s;
   assign w_sclk_fall = r_sclk_d & ~w_sclk_s;
   assign w_abort     = (r_state == ST_ACTIVE) & w_cs_rise & (r_edge_cnt != 4'd0);
   assign w_wrap      = (r_state == ST_ACTIVE) & ~w_cs_rise & w_sclk_rise & (r_edge_cnt == 4'd15);

   // Channel value mux; addresses at or beyond NUM_CH match nothing and return zero.
   always_comb begin
      w_ch_sel = 12'h000;
      for (int k = 0; k < NUM_CH; k++) begin
         w_ch_sel = w_ch_sel | ((r_cur_ch == 3'(k)) ? ch_data[12*k +: 12] : 12'h000);
      end
   end

`ifdef ADC_RESP_RAMP_EN
   logic [11:0] r_ramp [NUM_CH];
   logic [11:0] w_ramp_sel;

   // Ramp counters advance only when a completed frame returned that channel.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_CH; k++) begin
            r_ramp[k] <= 12'(k * 256);
         end
      end else if (w_wrap) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (r_cur_ch == 3'(k)) begin
               r_ramp[k] <= r_ramp[k] + 12'd1;
            end
         end
      end
   end

   // Ramp value mux for the channel of the frame in flight.
   always_comb begin
      w_ramp_sel = 12'h000;
      for (int k = 0; k < NUM_CH; k++) begin
         w_ramp_sel = w_ramp_sel | ((r_cur_ch == 3'(k)) ? r_ramp[k] : 12'h000);
      end
   end

   assign w_load_data = ramp_en ? w_ramp_sel : w_ch_sel;
`else
   logic w_unused_ramp;
   assign w_unused_ramp = ramp_en;
   assign w_load_data   = w_ch_sel;
`endif

   // Frame state machine; a CS_N rise takes priority over any SCLK edge in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_edge_cnt   <= 4'd0;
         r_addr_tmp   <= 2'b00;
         r_next_ch    <= 3'd0;
         r_cur_ch     <= 3'd0;
         r_shift      <= 11'd0;
         r_sdat       <= 1'b0;
         r_sdat_oe    <= 1'b0;
         r_frame_done <= 1'b0;
         r_frame_ch   <= 3'd0;
         r_proto_err  <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_sdat     <= 1'b0;
               r_edge_cnt <= 4'd0;
               if (w_cs_fall) begin
                  r_state   <= ST_ACTIVE;
                  r_sdat_oe <= 1'b1;
                  r_cur_ch  <= r_next_ch;
               end else begin
                  r_sdat_oe <= 1'b0;
               end
            end
            ST_ACTIVE: begin
               if (w_cs_rise) begin
                  r_sdat_oe  <= 1'b0;
                  r_sdat     <= 1'b0;
                  r_edge_cnt <= 4'd0;
                  r_state    <= (r_edge_cnt == 4'd0) ? ST_IDLE : ST_ABORT;
               end else if (w_sclk_rise) begin
                  r_edge_cnt <= r_edge_cnt + 4'd1;
                  case (r_edge_cnt)
                     4'd2:    r_addr_tmp[1] <= w_saddr_s;
                     4'd3:    r_addr_tmp[0] <= w_saddr_s;
                     4'd4:    r_next_ch     <= {r_addr_tmp, w_saddr_s};
                     4'd15: begin
                        r_frame_done <= 1'b1;
                        r_frame_ch   <= r_cur_ch;
                        r_cur_ch     <= r_next_ch;
                     end
                     default: r_addr_tmp <= r_addr_tmp;
                  endcase
               end else if (w_sclk_fall) begin
                  if (r_edge_cnt == 4'd3) begin
                     r_sdat  <= w_load_data[11];
                     r_shift <= w_load_data[10:0];
                  end else if ((r_edge_cnt >= 4'd4) && (r_edge_cnt <= 4'd14)) begin
                     r_sdat  <= r_shift[10];
                     r_shift <= {r_shift[9:0], 1'b0};
                  end else begin
                     r_sdat <= 1'b0;
                  end
               end else begin
                  r_sdat_oe <= 1'b1;
               end
            end
            ST_ABORT: begin
               r_state   <= ST_IDLE;
               r_sdat_oe <= 1'b0;
               r_sdat    <= 1'b0;
            end
            default: begin
               r_state   <= ST_IDLE;
               r_sdat_oe <= 1'b0;
               r_sdat    <= 1'b0;
            end
         endcase
         // A new abort outranks a simultaneous clear.
         if (w_abort) begin
            r_proto_err <= 1'b1;
         end else if (err_clr) begin
            r_proto_err <= 1'b0;
         end else begin
            r_proto_err <= r_proto_err;
         end
      end
   end

   assign adc_sdat    = r_sdat;
   assign adc_sdat_oe = r_sdat_oe;
   assign frame_done  = r_frame_done;
   assign frame_ch    = r_frame_ch;
   assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: an 8-channel and a 4-channel instance share the serial pins.
// Ramp-mode checks are compiled in when ADC_RESP_RAMP_EN is defined.
module tb_adc_spi_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cs_n = 1'b1;
   logic        sclk = 1'b1;
   logic        saddr = 1'b0;
   logic        ramp_en = 1'b0;
   logic        err_clr = 1'b0;
   logic [95:0] ch_data;
   logic [47:0] ch_data4;

   logic        sdat, oe, fdone, perr;
   logic [2:0]  fch;
   logic        sdat4, oe4, fdone4, perr4;
   logic [2:0]  fch4;

   int n_cmp = 0;
   int n_err = 0;
   int fd_total = 0;

   always #10 clk = ~clk;

   adc_spi_responder #(.NUM_CH(8), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .adc_cs_n(cs_n), .adc_sclk(sclk), .adc_saddr(saddr),
      .adc_sdat(sdat), .adc_sdat_oe(oe), .ch_data(ch_data), .ramp_en(ramp_en),
      .frame_done(fdone), .frame_ch(fch), .proto_err(perr), .err_clr(err_clr)
   );

   adc_spi_responder #(.NUM_CH(4), .SYNC_STAGES(2)) dut4 (
      .clk(clk), .reset(reset), .adc_cs_n(cs_n), .adc_sclk(sclk), .adc_saddr(saddr),
      .adc_sdat(sdat4), .adc_sdat_oe(oe4), .ch_data(ch_data4), .ramp_en(ramp_en),
      .frame_done(fdone4), .frame_ch(fch4), .proto_err(perr4), .err_clr(err_clr)
   );

   always @(posedge clk) begin
      if (fdone) fd_total <= fd_total + 1;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Initiator drives SCLK at clk/16; bit i is sampled just before falling edge i+1.
   task automatic run_frame(input int n_rise, input logic [2:0] addr,
                            output logic [15:0] b8, output logic [15:0] b4);
      b8 = 16'h0000;
      b4 = 16'h0000;
      for (int i = 0; i < n_rise; i++) begin
         b8[15-i] = sdat;
         b4[15-i] = sdat4;
         sclk = 1'b0;
         saddr = (i == 2) ? addr[2] : (i == 3) ? addr[1] : (i == 4) ? addr[0] : 1'b0;
         wait_clk(8);
         sclk = 1'b1;
         wait_clk(8);
      end
   endtask

   task automatic test_reset;
      wait_clk(4);
      if (sdat !== 1'b0) begin $display("FAIL rst_sdat: got %b want 0", sdat); n_err++; end
      n_cmp++;
      if (oe !== 1'b0) begin $display("FAIL rst_oe: got %b want 0", oe); n_err++; end
      n_cmp++;
      if (fdone !== 1'b0) begin $display("FAIL rst_fdone: got %b want 0", fdone); n_err++; end
      n_cmp++;
      if (perr !== 1'b0) begin $display("FAIL rst_perr: got %b want 0", perr); n_err++; end
      n_cmp++;
      if (fch !== 3'd0) begin $display("FAIL rst_fch: got %0d want 0", fch); n_err++; end
      n_cmp++;
      reset = 1'b0;
      wait_clk(6);
      if (oe !== 1'b0) begin $display("FAIL idle_oe: got %b want 0", oe); n_err++; end
      n_cmp++;
   endtask

   task automatic test_reset_frame;
      logic [15:0] b, b4;
      int fd0;
      fd0 = fd_total;
      cs_n = 1'b0;
      wait_clk(2);
      if (oe !== 1'b0) begin $display("FAIL oe_early: got %b want 0", oe); n_err++; end
      n_cmp++;
      wait_clk(1);
      if (oe !== 1'b1) begin $display("FAIL oe_lat3: got %b want 1", oe); n_err++; end
      n_cmp++;
      wait_clk(5);
      run_frame(16, 3'd0, b, b4);
      cs_n = 1'b1;
      wait_clk(3);
      if (oe !== 1'b0) begin $display("FAIL oe_off_lat3: got %b want 0", oe); n_err++; end
      n_cmp++;
      wait_clk(5);
      if (b !== 16'h0ABC) begin $display("FAIL reset_frame_bits: got %h want 0abc", b); n_err++; end
      n_cmp++;
      if (fd_total - fd0 !== 1) begin $display("FAIL reset_frame_done: got %0d want 1", fd_total - fd0); n_err++; end
      n_cmp++;
      if (fch !== 3'd0) begin $display("FAIL reset_frame_ch: got %0d want 0", fch); n_err++; end
      n_cmp++;
   endtask

   task automatic test_pipeline;
      logic [15:0] b1, b2, x;
      int fd0;
      fd0 = fd_total;
      cs_n = 1'b0;
      wait_clk(8);
      run_frame(16, 3'd5, b1, x);
      run_frame(16, 3'd0, b2, x);
      cs_n = 1'b1;
      wait_clk(8);
      if (b1 !== 16'h0ABC) begin $display("FAIL pipe_frame1: got %h want 0abc", b1); n_err++; end
      n_cmp++;
      if (b2 !== 16'h05A5) begin $display("FAIL pipe_frame2: got %h want 05a5", b2); n_err++; end
      n_cmp++;
      if (fch !== 3'd5) begin $display("FAIL pipe_ch: got %0d want 5", fch); n_err++; end
      n_cmp++;
      if (fd_total - fd0 !== 2) begin $display("FAIL pipe_done: got %0d want 2", fd_total - fd0); n_err++; end
      n_cmp++;
   endtask

   task automatic test_truncated;
      logic [15:0] b, x;
      int fd0;
      fd0 = fd_total;
      if (perr !== 1'b0) begin $display("FAIL trunc_pre_perr: got %b want 0", perr); n_err++; end
      n_cmp++;
      cs_n = 1'b0;
      wait_clk(8);
      run_frame(9, 3'd1, b, x);
      cs_n = 1'b1;
      wait_clk(3);
      if (oe !== 1'b0) begin $display("FAIL trunc_oe: got %b want 0", oe); n_err++; end
      n_cmp++;
      if (perr !== 1'b1) begin $display("FAIL trunc_perr: got %b want 1", perr); n_err++; end
      n_cmp++;
      wait_clk(5);
      if (fd_total - fd0 !== 0) begin $display("FAIL trunc_done: got %0d want 0", fd_total - fd0); n_err++; end
      n_cmp++;
      err_clr = 1'b1;
      wait_clk(1);
      err_clr = 1'b0;
      if (perr !== 1'b0) begin $display("FAIL trunc_clr: got %b want 0", perr); n_err++; end
      n_cmp++;
      wait_clk(4);
   endtask

   task automatic test_mid_reset;
      logic [15:0] b, x;
      logic oe_bad;
      int fd0;
      cs_n = 1'b0;
      wait_clk(8);
      run_frame(16, 3'd3, b, x);
      run_frame(7, 3'd0, b, x);
      reset = 1'b1;
      wait_clk(1);
      reset = 1'b0;
      fd0 = fd_total;
      wait_clk(1);
      if (oe !== 1'b0) begin $display("FAIL mrst_oe: got %b want 0", oe); n_err++; end
      n_cmp++;
      oe_bad = 1'b0;
      for (int i = 0; i < 9; i++) begin
         sclk = 1'b0;
         for (int j = 0; j < 8; j++) begin wait_clk(1); oe_bad = oe_bad | oe; end
         sclk = 1'b1;
         for (int j = 0; j < 8; j++) begin wait_clk(1); oe_bad = oe_bad | oe; end
      end
      if (oe_bad !== 1'b0) begin $display("FAIL mrst_silent: got %b want 0", oe_bad); n_err++; end
      n_cmp++;
      if (fd_total - fd0 !== 0) begin $display("FAIL mrst_done: got %0d want 0", fd_total - fd0); n_err++; end
      n_cmp++;
      cs_n = 1'b1;
      wait_clk(8);
      cs_n = 1'b0;
      wait_clk(8);
      run_frame(16, 3'd0, b, x);
      cs_n = 1'b1;
      wait_clk(8);
      if (b !== 16'h0ABC) begin $display("FAIL mrst_frame: got %h want 0abc", b); n_err++; end
      n_cmp++;
      if (fch !== 3'd0) begin $display("FAIL mrst_ch: got %0d want 0", fch); n_err++; end
      n_cmp++;
   endtask

   task automatic test_out_of_range;
      logic [15:0] a8, a4, b8, b4;
      cs_n = 1'b0;
      wait_clk(8);
      run_frame(16, 3'd6, a8, a4);
      run_frame(16, 3'd0, b8, b4);
      cs_n = 1'b1;
      wait_clk(8);
      if (a4 !== 16'h0ABC) begin $display("FAIL oor_pre4: got %h want 0abc", a4); n_err++; end
      n_cmp++;
      if (b4 !== 16'h0000) begin $display("FAIL oor_ch6_4: got %h want 0000", b4); n_err++; end
      n_cmp++;
      if (b8 !== 16'h0666) begin $display("FAIL oor_ch6_8: got %h want 0666", b8); n_err++; end
      n_cmp++;
      if (fch !== 3'd6) begin $display("FAIL oor_ch: got %0d want 6", fch); n_err++; end
      n_cmp++;
   endtask

`ifdef ADC_RESP_RAMP_EN
   task automatic test_ramp;
      logic [15:0] b1, b2, b3, x;
      ramp_en = 1'b1;
      cs_n = 1'b0;
      wait_clk(8);
      run_frame(16, 3'd2, x, x);
      run_frame(16, 3'd2, b1, x);
      run_frame(16, 3'd2, b2, x);
      cs_n = 1'b1;
      wait_clk(8);
      cs_n = 1'b0;
      wait_clk(8);
      run_frame(9, 3'd2, x, x);
      cs_n = 1'b1;
      wait_clk(8);
      if (perr !== 1'b1) begin $display("FAIL ramp_abort_perr: got %b want 1", perr); n_err++; end
      n_cmp++;
      err_clr = 1'b1;
      wait_clk(1);
      err_clr = 1'b0;
      cs_n = 1'b0;
      wait_clk(8);
      run_frame(16, 3'd2, b3, x);
      cs_n = 1'b1;
      wait_clk(8);
      ramp_en = 1'b0;
      if (b1 !== 16'h0200) begin $display("FAIL ramp_0: got %h want 0200", b1); n_err++; end
      n_cmp++;
      if (b2 !== 16'h0201) begin $display("FAIL ramp_1: got %h want 0201", b2); n_err++; end
      n_cmp++;
      if (b3 !== 16'h0202) begin $display("FAIL ramp_2: got %h want 0202", b3); n_err++; end
      n_cmp++;
   endtask
`endif

   initial begin
      for (int k = 0; k < 8; k++) ch_data[12*k +: 12] = {4'(k), 8'h11};
      ch_data[11:0]  = 12'hABC;
      ch_data[47:36] = 12'h333;
      ch_data[71:60] = 12'h5A5;
      ch_data[83:72] = 12'h666;
      ch_data4 = ch_data[47:0];
      test_reset();
      test_reset_frame();
      test_pipeline();
      test_truncated();
      test_mid_reset();
      test_out_of_range();
`ifdef ADC_RESP_RAMP_EN
      test_ramp();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Serial-ADC responder: the device end of the 3-wire ADC link (CS_N/SCLK/SADDR in, SDAT out) that the IMU controller drives as initiator. It emulates an 8-channel, 12-bit ADC128S022-style converter. Values come from a parallel channel bus, so IMU firmware and the controller can be exercised on a second board or in hardware-in-the-loop without the physical ADC. All serial inputs are oversampled in the single `clk` domain; nothing is clocked by SCLK.

## Interface
Parameters:
- `NUM_CH`, 8: number of channels; address width is fixed at 3 bits.
- `SYNC_STAGES`, 2: synchronizer depth on `adc_cs_n`, `adc_sclk` and `adc_saddr`; minimum 2.

Ports:
- `clk` in 1: system clock, 50 MHz; must be at least 8× SCLK.
- `reset` in 1: synchronous, active-high reset.
- `adc_cs_n` in 1: frame select, active low.
- `adc_sclk` in 1: serial clock from the initiator; idles high.
- `adc_saddr` in 1: address bit stream (DIN).
- `adc_sdat` out 1: data bit stream (DOUT).
- `adc_sdat_oe` out 1: output enable for the top-level tristate driving `adc_sdat`.
- `ch_data` in `12*NUM_CH`: channel values; channel k occupies `[12k+11:12k]`.
- `ramp_en` in 1: selects test-ramp data. Ignored unless the configuration macro is defined.
- `frame_done` out 1: one-cycle pulse when a full 16-bit frame completes.
- `frame_ch` out 3: channel returned in the last completed frame.
- `proto_err` out 1: sticky flag for a truncated frame.
- `err_clr` in 1: clears `proto_err`.

## Operation
- **Input conditioning.** Each serial input passes through a `SYNC_STAGES` flop synchronizer. Edges are detected by comparing the synchronized value with a one-cycle delayed copy.
- **State machine.** States are IDLE, ACTIVE and ABORT.
  - IDLE → ACTIVE on a synchronized CS_N fall.
  - ACTIVE → IDLE on a CS_N rise when `edge_cnt` = 0.
  - ACTIVE → ABORT on a CS_N rise when `edge_cnt` ≠ 0.
  - ABORT → IDLE on the next cycle. ABORT sets `proto_err`.
- **Edge counter.** `edge_cnt` is 4 bits, counts rising SCLK edges while ACTIVE, and wraps 15→0. The rising edge that causes the wrap pulses `frame_done`, updates `frame_ch`, and starts the next frame with CS_N still low (continuous conversion).
- **Address capture.**
  - ADD2, ADD1 and ADD0 are sampled on rising edges 3, 4 and 5 of a frame into a temporary register.
  - The temporary value is committed to `next_ch` on rising edge 5.
  - `next_ch` selects the channel for the following frame. It persists across CS_N-high periods.
  - Reset sets `next_ch` to 0, so the first frame after reset returns channel 0.
  - An address with value ≥ `NUM_CH` returns 0x000.
- **Data output.**
  - On CS_N fall, `adc_sdat_oe` goes to 1 and `adc_sdat` to 0 (leading zero 1).
  - On falling SCLK edges 1–3, `adc_sdat` is 0 (leading zeros 2–4).
  - On falling edge 4, the shift register loads `ch_data[cur_ch]` and `adc_sdat` presents DB11.
  - Falling edges 5–15 present DB10 through DB0, MSB first.
  - Falling edge 16 presents 0; it is the leading zero of the next frame if CS_N stays low.
  - `cur_ch` = `next_ch` as sampled at the frame start.
- **End of frame.** When CS_N is high, `adc_sdat_oe` = 0 and `adc_sdat` = 0.
- **Error clear.** `err_clr` clears `proto_err`. If `err_clr` and a new abort occur in the same cycle, set wins.

## Timing
- Reset values: `adc_sdat` 0, `adc_sdat_oe` 0, `frame_done` 0, `frame_ch` 0, `proto_err` 0, state IDLE, `edge_cnt` 0, `next_ch` 0.
- Pin-to-response latency is `SYNC_STAGES` + 1 clk. With the default of 2, `adc_sdat` and `adc_sdat_oe` change exactly 3 clk after the pin edge.
- `ch_data` is sampled once per frame, in the cycle falling edge 4 is detected; later changes do not affect the frame in flight.
- `frame_done` is high for exactly one clk, in the cycle the 16th rising edge is detected.
- A CS_N rise and an SCLK edge detected in the same cycle: the CS_N rise wins and the SCLK edge is ignored.
- Reset asserted mid-frame: all state returns to reset values on the next clk. The responder stays silent (`adc_sdat_oe` = 0) until a fresh CS_N fall, even if CS_N is still low.

## Configuration
- Macro: `ADC_RESP_RAMP_EN`.
- **Defined:** each channel has a 12-bit ramp counter, reset to `12'h000 + (k << 8)`. When `ramp_en` = 1, falling edge 4 loads the ramp value for `cur_ch` instead of `ch_data`. That channel's counter increments by 1, wrapping 0xFFF→0x000, on the `frame_done` of every completed frame that returned it. Aborted frames do not increment.
- **Not defined:** no ramp counters are synthesized, `ramp_en` is unused, and data always comes from `ch_data`.

## Test plan
- **Reset frame.** After reset, `ch_data` ch0 = 0xABC, SADDR = 0, one 16-clock frame at 3.125 MHz → DOUT bits `0000_1010_1011_1100`; `frame_done` pulses once; `frame_ch` = 0.
- **Address pipelining.** Frame 1 sends ADD = 5 (`ch_data` ch5 = 0x5A5) → frame 1 returns ch0. Frame 2 with CS_N held low → returns 0x5A5 and `frame_ch` = 5.
- **Truncated frame.** CS_N rises after 9 SCLK rises → `proto_err` = 1, `adc_sdat_oe` = 0 within 3 clk, no `frame_done`. `err_clr` → `proto_err` = 0.
- **Mid-frame reset.** `reset` pulsed at rising edge 7 with CS_N held low → `adc_sdat_oe` = 0 and stays 0 until CS_N toggles. The next frame returns ch0.
- **Out-of-range address.** `NUM_CH` = 4, ADD = 6 → the next frame returns 0x000.
- **Ramp mode.** With `ADC_RESP_RAMP_EN` defined and `ramp_en` = 1, three ch2 frames → 0x200, 0x201, 0x202. A ch2 frame aborted in between does not advance the sequence.
